game_countdown_timer: RTL

Round countdown timer for the game logic. It consumes the 1 ms strobe from `millisecond_timer` and counts down a loadable number of seconds. It supports start, pause and reload, and reports the remaining time as binary and two BCD digits for the HUD digit renderer. It raises a one-cycle expiry pulse plus a sticky expired flag, which the game state machine uses to end the round.

---
 rtl/game_countdown_timer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/game_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : game_countdown_timer
// Purpose  : Round countdown timer. Counts down a loadable number of whole
//            seconds from the 1 ms strobe, with start / pause / reload, and
//            reports the remaining time in binary and as two BCD digits.
//            Raises a one-cycle expiry pulse plus a sticky expired flag.
// Ports    :
//   clk_40MHz      in   system clock, rising edge
//   rst            in   asynchronous active-low reset
//   one_milli_tick in   single-cycle 1 ms strobe
//   load           in   reload seconds_left from load_seconds, go IDLE
//   load_seconds   in   reload value (clamped to 99)
//   start          in   begin / resume counting
//   pause          in   freeze counting
//   seconds_left   out  remaining whole seconds, binary
//   bcd_tens       out  tens digit of seconds_left (one cycle behind)
//   bcd_ones       out  ones digit of seconds_left (one cycle behind)
//   running        out  high while counting
//   expired        out  sticky, high once the round has run out
//   expire_pulse   out  one-cycle pulse on expiry
// Revision : 1.0 - initial release
// ============================================================================
module game_countdown_timer #(
  parameter int TICKS_PER_SEC   = 1000,
  parameter int SEC_W           = 7,
  parameter int DEFAULT_SECONDS = 60
) (
  input  logic             clk_40MHz,
  input  logic             rst,
  input  logic             one_milli_tick,
  input  logic             load,
  input  logic [SEC_W-1:0] load_seconds,
  input  logic             start,
  input  logic             pause,
  output logic [SEC_W-1:0] seconds_left,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             running,
  output logic             expired,
  output logic             expire_pulse
);

  localparam int               MS_W        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [MS_W-1:0]  MS_LAST     = MS_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_MAX     = SEC_W'(99);
  localparam logic [SEC_W-1:0] SEC_DEFAULT = SEC_W'(DEFAULT_SECONDS);
  localparam logic [SEC_W-1:0] SEC_TEN     = SEC_W'(10);
  localparam logic [3:0]       DEF_TENS    = 4'(DEFAULT_SECONDS / 10);
  localparam logic [3:0]       DEF_ONES    = 4'(DEFAULT_SECONDS % 10);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [MS_W-1:0]  ms_cnt;
  logic [MS_W-1:0]  ms_cnt_nxt;
  logic [SEC_W-1:0] sec_nxt;
  logic [SEC_W-1:0] load_clamped;
  logic             pulse_nxt;

  always_comb begin
    load_clamped = (load_seconds > SEC_MAX) ? SEC_MAX : load_seconds;
  end

  // Next-state logic. load overrides everything; otherwise each state only
  // reacts to the requests that are meaningful for it.
  always_comb begin
    state_nxt  = state;
    ms_cnt_nxt = ms_cnt;
    sec_nxt    = seconds_left;

    if (load) begin
      state_nxt  = ST_IDLE;
      ms_cnt_nxt = '0;
      sec_nxt    = load_clamped;
    end else begin
      case (state)
        ST_IDLE: begin
          // pause has no meaning before the round starts, so it never
          // blocks a start here.
          if (start) begin
            state_nxt = (seconds_left == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          // A pause freezes the partial second exactly; any coincident
          // tick is dropped.
          if (pause) begin
            state_nxt = ST_PAUSE;
          end else if (one_milli_tick) begin
            if (ms_cnt == MS_LAST) begin
              ms_cnt_nxt = '0;
              if (seconds_left != '0) begin
                sec_nxt = seconds_left - SEC_W'(1);
              end
              if (seconds_left <= SEC_W'(1)) begin
                state_nxt = ST_DONE;
              end
            end else begin
              ms_cnt_nxt = ms_cnt + MS_W'(1);
            end
          end
        end
        ST_PAUSE: begin
          if (start && !pause) begin
            state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          sec_nxt = '0;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end

    pulse_nxt = (state_nxt == ST_DONE) && (state != ST_DONE);
  end

  always_ff @(posedge clk_40MHz or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      ms_cnt       <= '0;
      seconds_left <= SEC_DEFAULT;
      expire_pulse <= 1'b0;
      bcd_tens     <= DEF_TENS;
      bcd_ones     <= DEF_ONES;
    end else begin
      state        <= state_nxt;
      ms_cnt       <= ms_cnt_nxt;
      seconds_left <= sec_nxt;
      expire_pulse <= pulse_nxt;
      // Digits follow the registered binary value, hence one cycle behind.
      bcd_tens     <= 4'(seconds_left / SEC_TEN);
      bcd_ones     <= 4'(seconds_left % SEC_TEN);
    end
  end

  assign running = (state == ST_RUN);
  assign expired = (state == ST_DONE);

endmodule
`default_nettype wire
